// File: rtl/aes128_iter_ctrl_if.sv
// Block-in / ciphertext-out handshake bundle for the iterative AES-128 engine.
interface aes128_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;
  logic [3:0]   round;

  modport master (
    output in_valid, pt_in, key_in, out_ready,
    input  in_ready, out_valid, ct_out, round
  );

  modport slave (
    input  in_valid, pt_in, key_in, out_ready,
    output in_ready, out_valid, ct_out, round
  );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly,
// ciphertext held under valid/ready backpressure.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = affine(gf_inv(in_byte));
endmodule

module sub_byte (
  input  logic [127:0] in_state,
  output logic [127:0] out_state
);
  for (genvar g = 0; g < 16; g++) begin : g_sb
    sbox u_sbox (.in_byte(in_state[8*g +: 8]), .out_byte(out_state[8*g +: 8]));
  end
endmodule

module aes128_iter_ctrl (
  input logic                clk,
  input logic                rst_n,
  aes128_iter_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] sb_s, sr_s, mc_s, rnd_s, next_key_s;
  logic [31:0]  rot_s, subw_s, w0_s, w1_s, w2_s, w3_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  sub_byte u_sub_byte (.in_state(state_q), .out_state(sb_s));

  assign rot_s = {key_q[23:0], key_q[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_ks
    sbox u_sbox (.in_byte(rot_s[8*g +: 8]), .out_byte(subw_s[8*g +: 8]));
  end

  assign w0_s       = key_q[127:96] ^ subw_s ^ {rcon(round_q), 24'h000000};
  assign w1_s       = key_q[95:64] ^ w0_s;
  assign w2_s       = key_q[63:32] ^ w1_s;
  assign w3_s       = key_q[31:0] ^ w2_s;
  assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

  // ShiftRows and MixColumns; byte i of the state sits at [127-8i -: 8], column-major.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr_s = 128'd0;
    mc_s = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr_s[127-32*c -: 8];
      a1 = sr_s[119-32*c -: 8];
      a2 = sr_s[111-32*c -: 8];
      a3 = sr_s[103-32*c -: 8];
      mc_s[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_s[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_s[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_s[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign rnd_s = ((round_q == 4'd10) ? sr_s : mc_s) ^ next_key_s;

  // Next-state and datapath register inputs.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.pt_in ^ bus.key_in;
          key_d   = bus.key_in;
          round_d = 4'd1;
          fsm_d   = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = rnd_s;
        key_d   = next_key_s;
        if (round_q == 4'd10) begin
          ct_d    = rnd_s;
          round_d = 4'd0;
          fsm_d   = HOLD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      HOLD: begin
        if (bus.out_ready) fsm_d = IDLE;
        else               fsm_d = HOLD;
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // State, key, round and ciphertext registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= 128'd0;
      key_q   <= 128'd0;
      ct_q    <= 128'd0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      round_q <= round_d;
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == HOLD);
  assign bus.ct_out    = ct_q;
  assign bus.round     = round_q;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 / SP800-38A known-answer vectors.
module tb_aes128_iter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  aes128_iter_ctrl_if bus ();
  aes128_iter_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P_D  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_D  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] exp);
    int lat;
    check({tag, "_in_ready_pre"}, 128'(bus.in_ready), 128'd1);
    bus.key_in   = k;
    bus.pt_in    = p;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.key_in   = ~k;
    bus.pt_in    = ~p;
    check({tag, "_round_e1"}, 128'(bus.round), 128'd1);
    check({tag, "_in_ready_busy"}, 128'(bus.in_ready), 128'd0);
    wait_valid(lat);
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_ct"}, bus.ct_out, exp);
    check({tag, "_round_hold"}, 128'(bus.round), 128'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_done"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_in_ready_done"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    int lat;
    int acc_cyc [4];
    logic [127:0] keys [4];
    logic [127:0] pts  [4];
    logic [127:0] cts  [4];

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pt_in     = 128'd0;
    bus.key_in    = 128'd0;

    // Reset values.
    @(posedge clk); #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_ct", bus.ct_out, 128'd0);
    check("rst_round", 128'(bus.round), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle is harmless.
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_out_ready", 128'(bus.in_ready), 128'd1);

    run_vec("c1", K_C1, P_C1, C_C1);
    run_vec("zero", 128'd0, 128'd0, C_Z);

    // Backpressure: App. B result held 20 cycles while other data is offered.
    bus.key_in = K_B; bus.pt_in = P_B; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_in = 128'd0; bus.pt_in = 128'd0;
    wait_valid(lat);
    check("bp_latency", 128'(lat), 128'd10);
    check("bp_ct", bus.ct_out, C_B);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_ct_stable", bus.ct_out, C_B);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_accept_round", 128'(bus.round), 128'd1);
    check("bp_next_accept_busy", 128'(bus.in_ready), 128'd0);
    wait_valid(lat);
    check("bp_next_latency", 128'(lat), 128'd10);
    check("bp_next_ct", bus.ct_out, C_Z);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Asynchronous reset at round 5.
    bus.key_in = K_C1; bus.pt_in = P_C1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("mid_round5", 128'(bus.round), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("mid_rst_round", 128'(bus.round), 128'd0);
    check("mid_rst_ct", bus.ct_out, 128'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("c1_after_rst", K_C1, P_C1, C_C1);

    // Continuous stream with in_valid and out_ready held high.
    keys[0] = K_C1;   pts[0] = P_C1;   cts[0] = C_C1;
    keys[1] = K_B;    pts[1] = P_B;    cts[1] = C_B;
    keys[2] = 128'd0; pts[2] = 128'd0; cts[2] = C_Z;
    keys[3] = K_B;    pts[3] = P_D;    cts[3] = C_D;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.key_in = keys[k];
      bus.pt_in  = pts[k];
      check("stream_in_ready", 128'(bus.in_ready), 128'd1);
      @(posedge clk); #1;
      acc_cyc[k] = cyc;
      wait_valid(lat);
      check("stream_latency", 128'(lat), 128'd10);
      check("stream_ct", bus.ct_out, cts[k]);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check("stream_period", 128'(acc_cyc[k] - acc_cyc[k-1]), 128'd12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes128_iter_ctrl.md
# aes128_iter_ctrl

Iterative AES-128 encryption engine controller. It accepts one 128-bit plaintext and key per transaction and runs one full round per clock through a single shared `sub_byte` instance for the state. It derives round keys on the fly with four `sbox` instances, and presents the ciphertext under a valid/ready handshake with backpressure. It sits between the host-side block buffer and the ciphertext output stage.

## Interface
- No parameters. Nr = 10 and the 128-bit key size are fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `pt_in` and `key_in` are valid.
- `in_ready` out 1: block can accept a new transaction.
- `pt_in` in 128: plaintext. Byte 0 is [127:120]; column-major per FIPS-197.
- `key_in` in 128: cipher key, same byte order.
- `out_valid` out 1: `ct_out` holds a finished ciphertext.
- `out_ready` in 1: downstream accepts `ct_out`.
- `ct_out` out 128: ciphertext.
- `round` out 4: current round index (0 in IDLE), for debug.

## Operation
- States: IDLE, RUN, HOLD. The reset state is IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `ct_out`=0, `round`=0, state register=0, key register=0.
- `in_ready` = (state==IDLE). `out_valid` = (state==HOLD).

IDLE:
- On `in_valid`&`in_ready`: state_reg <= `pt_in`^`key_in` (round 0 AddRoundKey), key_reg <= `key_in`, round <= 1, go to RUN.
- Otherwise hold.

RUN, round r (1..10), one edge per round:
- next_key = KeyExpand(key_reg, rcon[r]).
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - w0 = key_reg[127:96].
  - SubWord uses 4 `sbox` instances.
- state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), next_key).
  - SubBytes goes through the single `sub_byte` instance.
  - For r==10, MixColumns is bypassed.
- key_reg <= next_key.
- round <= r+1 for r<10.
- At r==10: `ct_out` <= round result, round <= 0, go to HOLD.

HOLD:
- `ct_out` is stable and `out_valid`=1 until `out_ready` is sampled high.
- Then go to IDLE.
- `out_ready` low holds indefinitely, with no timeout.

Arithmetic:
- MixColumns uses GF(2^8) with xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- The column matrix is [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- All datapath logic is combinational between state_reg/key_reg and their D inputs. There is no pipelining.

Boundary conditions:
- `in_valid` during RUN/HOLD is ignored; `in_ready`=0, so no data is captured.
- `out_ready` high while not in HOLD has no effect.
- `out_ready` high on the same edge HOLD is entered has no effect, because HOLD is entered at that edge.
- `rst_n` low mid-RUN or in HOLD:
  - Immediate return to IDLE with all reset values.
  - The partial result is discarded.
  - `out_valid` drops asynchronously.
- Inputs `pt_in`/`key_in` are only sampled on the accept edge. They may change freely afterwards.

## Timing
- Accept edge = E0. Rounds complete on E1..E10.
- `out_valid` rises after E10, giving a latency of 10 cycles from accept to `out_valid`.
- With `out_ready` tied high:
  - HOLD→IDLE at E11.
  - The next accept is at E12.
  - Throughput is one block per 12 cycles.
- `round` reads 1..10 during RUN, 0 in IDLE/HOLD.
- `in_ready` falls in the cycle after the accept edge and returns in the cycle after the output handshake.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> `ct_out` 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `out_valid` is exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Zero key, zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 20 cycles after `out_valid`: `ct_out` stable, `in_ready`=0, and a new `in_valid` with other data is ignored.
  - Release `out_ready`: the next vector is accepted exactly 1 cycle after the output handshake, and both results are correct.
- Reset mid-operation:
  - Assert `rst_n`=0 asynchronously at round 5: `out_valid`=0, `in_ready`=1, `round`=0 immediately.
  - After release, the C.1 vector produces the correct ciphertext.
- Continuous stream of 4 vectors with `in_valid`/`out_ready` held high: a 12-cycle period, all four outputs correct, in order.
